wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback, whose data is already selected by the writeback mux;
  - a long-latency unit, such as the multi-cycle mul/div or a slow load return.
- Pipeline writes always win. Long-latency results are parked in a small FIFO and drained into idle write-port cycles.
- An anti-starvation counter forces a pipeline bubble when needed.
- Sits between the writeback-mux output / long-latency unit and the register file write port.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go undrained before a bubble is forced
- CNT_W, 4, starvation counter width (must hold STARVE_LIMIT)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_valid  in  1  pipeline writeback request this cycle (cannot be stalled)
- p_rd  in  5  pipeline destination register
- p_data  in  32  pipeline writeback data (write_reg_data)
- s_valid  in  1  long-latency result valid
- s_ready  out  1  FIFO can accept (valid/ready handshake)
- s_rd  in  5  long-latency destination register
- s_data  in  32  long-latency result
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- pipe_stall  out  1  registered; requests a one-cycle pipeline bubble
- busy  out  1  FIFO non-empty

Behaviour:
- Write port is combinational from current inputs and FIFO head; all state updates on posedge clk.
- Reset (async): FIFO empty, pointers 0, starvation counter 0, pipe_stall=0, busy=0, s_ready=1. rf_we=0 whenever p_valid=0 and FIFO empty.
- Grant priority per cycle:
  - p_valid=1 and p_rd!=0: grant pipeline; rf_waddr=p_rd, rf_wdata=p_data.
  - Otherwise, FIFO non-empty: grant FIFO head; pop at clock edge.
  - Otherwise: rf_we=0.
- Writes to x0:
  - Pipeline write to x0 never asserts rf_we; that cycle counts as idle, so the FIFO may drain.
  - FIFO entries with rd=0 are still pushed and drained, but drain with rf_we=0.
- Push: s_valid & s_ready. s_ready = FIFO not full, or a pop occurs this cycle. Simultaneous push and pop on a full FIFO is allowed.
- Latency without bypass: an s result reaches rf_we no earlier than the cycle after acceptance.
- WAW squash:
  - If a pipeline write is granted with p_rd equal to the rd of any valid FIFO entry, those entries are marked dead. Pipeline data is newer.
  - Dead entries still pop in order but drain with rf_we=0.
  - An entry pushed in the same cycle with the same rd is not squashed; it is newer.
- FSM states: NORMAL, FORCE.
  - NORMAL: counter increments each cycle FIFO is non-empty and no pop occurs; resets to 0 on any pop or when empty.
  - Counter reaching STARVE_LIMIT-1 with no pop: next state FORCE, pipe_stall=1.
  - FORCE: upstream guarantees p_valid=0 this cycle; FIFO head drains; counter cleared; next state NORMAL, pipe_stall=0.
  - FIFO empty in FORCE: return to NORMAL, no write.
- busy=1 iff the FIFO holds at least one entry, live or dead.
- Reset mid-operation: all FIFO contents discarded; no write issued.

Optional Feature:
- Macro WBARB_BYPASS_EN.
- Defined: when the FIFO is empty and no pipeline write is granted (p_valid=0 or p_rd=0), an accepted s result writes the register file in the same cycle and is not pushed. Zero-cycle latency.
- Undefined: every s result passes through the FIFO; minimum one-cycle latency.

Test Plan:
- Reset, then s_valid with rd=5, data=0xDEAD0001, p_valid=0 -> next cycle rf_we=1, waddr=5, wdata=0xDEAD0001; busy falls. With WBARB_BYPASS_EN, the write happens in the same cycle.
- p_valid=1 (rd=3, 0x11) together with s_valid (rd=7, 0x22) -> cycle 0 writes x3=0x11; s result buffered; x7=0x22 written the first cycle p_valid=0.
- Fill FIFO with DEPTH entries while p_valid is held 1 -> s_ready=0. After STARVE_LIMIT undrained cycles, pipe_stall=1 for exactly one cycle; bench drops p_valid; head entry written; counter cleared.
- Push rd=9, 0xAAAA; next cycle pipeline writes x9=0xBBBB -> FIFO entry squashed; drains with rf_we=0; final x9=0xBBBB.
- Pipeline write to x0 with p_valid=1 and FIFO holding rd=4 -> rf_we=1 for x4 that cycle; x0 never written.
- Assert reset with 2 entries buffered -> busy=0, s_ready=1, pipe_stall=0 immediately; no rf_we after release until new requests.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline writeback, long-latency result and register-file write port bundle.
interface wb_port_arbiter_if;
    logic        p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic        busy;
    modport master(
        output p_valid, p_rd, p_data, s_valid, s_rd, s_data,
        input  s_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, busy
    );
    modport slave(
        input  p_valid, p_rd, p_data, s_valid, s_rd, s_data,
        output s_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and a long-latency FIFO.
// Optional same-cycle bypass of an empty FIFO when WBARB_BYPASS_EN is defined.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input logic             clk,
    input logic             reset,
    wb_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {NORMAL, FORCE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             stall;
    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_dead;
    logic [AW:0]      wptr, rptr;
    logic [AW-1:0]    head;
    logic             empty, full, p_grant, pop, push, byp;
    assign head    = rptr[AW-1:0];
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign p_grant = bus.p_valid && bus.p_rd != 5'd0;
    assign pop     = !p_grant && !empty;
`ifdef WBARB_BYPASS_EN
    assign byp     = empty && !p_grant && bus.s_valid;
`else
    assign byp     = 1'b0;
`endif
    assign bus.s_ready    = !full || pop;
    assign push           = bus.s_valid && bus.s_ready && !byp;
    assign bus.busy       = !empty;
    assign bus.pipe_stall = stall;
    // Dead or x0 entries still pop, they just never reach the register file.
    always_comb begin
        bus.rf_we    = p_grant || (pop && !q_dead[head] && q_rd[head] != 5'd0) || (byp && bus.s_rd != 5'd0);
        bus.rf_waddr = p_grant ? bus.p_rd : pop ? q_rd[head] : bus.s_rd;
        bus.rf_wdata = p_grant ? bus.p_data : pop ? q_data[head] : bus.s_data;
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr[AW-1:0]]   <= bus.s_rd;
            q_data[wptr[AW-1:0]] <= bus.s_data;
        end
    end
    // A newer pipeline write kills matching buffered results; the entry pushed this cycle is newer still.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr   <= '0;
            rptr   <= '0;
            q_dead <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (p_grant && q_rd[i] == bus.p_rd) q_dead[i] <= 1'b1;
            if (push) begin
                q_dead[wptr[AW-1:0]] <= 1'b0;
                wptr                 <= wptr + (AW+1)'(1);
            end
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NORMAL;
            cnt   <= '0;
            stall <= 1'b0;
        end else if (state == FORCE) begin
            state <= NORMAL;
            cnt   <= '0;
            stall <= 1'b0;
        end else if (empty || pop) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            state <= FORCE;
            cnt   <= '0;
            stall <= 1'b1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus against a queue-based model, checked by a scoreboard monitor.
module tb_wb_port_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;
    typedef struct {logic [4:0] rd; logic [31:0] data; bit dead;} ent_t;
    typedef struct {int cyc; logic [4:0] addr; logic [31:0] data;} wr_t;
    typedef struct {int cyc; bit we; bit sready; bit busy; bit stall;} st_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    wb_port_arbiter_if bus();
    wb_port_arbiter dut(.clk(clk), .reset(reset), .bus(bus));
    ent_t mq[$];
    wr_t  wq[$];
    st_t  sq[$];
    wr_t  mw;
    st_t  ms;
    int   run = 0;
    bit   mstall = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pprob = 50;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask
    task automatic step(bit pv, logic [4:0] prd, logic [31:0] pd, bit sv, logic [4:0] srd, logic [31:0] sd);
        bit   pg, emp, pop, sr, byp, we;
        wr_t  w;
        @(negedge clk);
        if (mstall) pv = 1'b0;
        bus.p_valid = pv; bus.p_rd = prd; bus.p_data = pd;
        bus.s_valid = sv; bus.s_rd = srd; bus.s_data = sd;
        pg  = pv && prd != 0;
        emp = mq.size() == 0;
        pop = !pg && !emp;
        sr  = mq.size() < DEPTH || pop;
        byp = 1'b0;
`ifdef WBARB_BYPASS_EN
        byp = emp && !pg && sv;
`endif
        we = 1'b0;
        w  = '{cyc, 5'd0, 32'd0};
        if (pg) begin
            we = 1'b1; w = '{cyc, prd, pd};
        end else if (pop) begin
            if (!mq[0].dead && mq[0].rd != 0) begin we = 1'b1; w = '{cyc, mq[0].rd, mq[0].data}; end
        end else if (byp && srd != 0) begin
            we = 1'b1; w = '{cyc, srd, sd};
        end
        sq.push_back('{cyc, we, sr, !emp, mstall});
        if (we) wq.push_back(w);
        foreach (mq[i]) if (pg && mq[i].rd == prd) mq[i].dead = 1'b1;
        if (pop) void'(mq.pop_front());
        if (sv && sr && !byp) mq.push_back('{srd, sd, 1'b0});
        if (mstall) begin
            mstall = 1'b0; run = 0;
        end else if (emp || pop) begin
            run = 0;
        end else begin
            run++;
            if (run == STARVE_LIMIT) begin mstall = 1'b1; run = 0; end
        end
    endtask
    task automatic idle(int n);
        repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask
    task automatic clear_inputs();
        bus.p_valid = 1'b0; bus.p_rd = '0; bus.p_data = '0;
        bus.s_valid = 1'b0; bus.s_rd = '0; bus.s_data = '0;
    endtask
    task automatic reset_checks(string tag);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_s_ready"}, bus.s_ready, 1'b1);
        chk({tag, "_pipe_stall"}, bus.pipe_stall, 1'b0);
        chk({tag, "_rf_we"}, bus.rf_we, 1'b0);
    endtask
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                if (sq.size() > 0) begin
                    ms = sq.pop_front();
                    chk("rf_we", bus.rf_we, ms.we);
                    chk("s_ready", bus.s_ready, ms.sready);
                    chk("busy", bus.busy, ms.busy);
                    chk("pipe_stall", bus.pipe_stall, ms.stall);
                end
                if (bus.rf_we) begin
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write at cycle %0d: got x%0d=%h expected no write", cyc, bus.rf_waddr, bus.rf_wdata);
                    end else begin
                        mw = wq.pop_front();
                        chk("write_cycle", cyc, mw.cyc);
                        chk("rf_waddr", bus.rf_waddr, mw.addr);
                        chk("rf_wdata", bus.rf_wdata, mw.data);
                    end
                end
            end
        end
    end
    initial begin
        clear_inputs();
        #1;
        reset_checks("reset");
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD0001);
        idle(2);
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        step(1'b1, 5'd4, 32'h33, 1'b0, 5'd0, 32'd0);
        idle(2);
        for (int i = 0; i < 14; i++) step(1'b1, 5'd1, $urandom, i < 3, 5'(10 + i), $urandom);
        idle(3);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAAAA);
        step(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        idle(2);
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44);
        step(1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0);
        idle(1);
        step(1'b1, 5'd1, 32'h61, 1'b1, 5'd20, 32'h20);
        step(1'b1, 5'd2, 32'h62, 1'b1, 5'd21, 32'h21);
        @(posedge clk);
        #2;
        reset = 1'b1;
        clear_inputs();
        #1;
        reset_checks("midreset");
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        run = 0;
        mstall = 1'b0;
        idle(4);
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) pprob = (c / 50) % 3 == 0 ? 30 : (c / 50) % 3 == 1 ? 75 : 100;
            step($urandom_range(0, 99) < pprob, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(6);
        #5;
        chk("pending_writes", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
